// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: scans one PMP entry per cycle through a single address comparator.
// Define PMP_FIXED_LATENCY_EN to always scan every entry (fixed latency) instead of exiting early.

module addr_check_n (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] addr_n,
  input  logic [31:0] addr_n_1,
  input  logic [1:0]  a_n,
  output logic        match
);
  logic [33:0] lo_b, hi_b, base, top;
  logic [31:0] keep;

  // An access matches only if every byte it touches lies inside the region.
  always_comb begin
    lo_b = {2'b00, addr};
    case (size)
      2'b00:   hi_b = lo_b;
      2'b01:   hi_b = lo_b + 34'd1;
      default: hi_b = lo_b + 34'd3;
    endcase
    base  = {addr_n_1, 2'b00};
    top   = {addr_n, 2'b00};
    // NAPOT: trailing ones plus the zero above them are don't-care bits.
    keep  = ~(addr_n ^ (addr_n + 32'd1));
    match = 1'b0;
    case (a_n)
      2'b01:   match = (lo_b >= base) && (hi_b < top);
      2'b10:   match = (lo_b[33:2] == addr_n) && (hi_b[33:2] == addr_n);
      2'b11:   match = ((lo_b[33:2] & keep) == (addr_n & keep)) &&
                       ((hi_b[33:2] & keep) == (addr_n & keep));
      default: match = 1'b0;
    endcase
  end
endmodule

module pmp_seq_checker #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [31:0]                      req_addr,
  input  logic [1:0]                       req_size,
  input  logic [1:0]                       req_type,
  input  logic                             req_priv_m,
  input  logic [NUM_ENTRIES-1:0][7:0]      pmpcfg,
  input  logic [NUM_ENTRIES-1:0][31:0]     pmpaddr,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_allow,
  output logic                             rsp_hit,
  output logic [3:0]                       rsp_entry,
  output logic                             busy
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  localparam logic [3:0] LAST = 4'(NUM_ENTRIES - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [31:0] q_addr;
  logic [1:0]  q_size, q_type;
  logic        q_priv;

  // Result of the entry checked last cycle; decisions are taken one cycle later.
  logic        p_vld, p_match, p_allow, p_last;
  logic [3:0]  p_idx;

  logic [15:0][7:0]  cfg_pad;
  logic [15:0][31:0] addr_pad;
  logic [7:0]  cur_cfg;
  logic [31:0] cur_addr, prev_addr;
  logic        chk_match, perm, allow_now, accept, reserved, scan_done;
  logic        res_hit, res_allow;
  logic [3:0]  res_entry;
  logic        cfg_unused;

`ifdef PMP_FIXED_LATENCY_EN
  logic        found, f_allow;
  logic [3:0]  f_idx;
`endif

  always_comb begin
    cfg_pad  = '0;
    addr_pad = '0;
    cfg_pad[NUM_ENTRIES-1:0]  = pmpcfg;
    addr_pad[NUM_ENTRIES-1:0] = pmpaddr;
  end

  assign cur_cfg    = cfg_pad[idx];
  assign cur_addr   = addr_pad[idx];
  assign prev_addr  = (idx == 4'd0) ? 32'h0 : addr_pad[idx - 4'd1];
  assign cfg_unused = ^cur_cfg[6:5];

  addr_check_n u_chk (
    .addr     (q_addr),
    .size     (q_size),
    .addr_n   (cur_addr),
    .addr_n_1 (prev_addr),
    .a_n      (cur_cfg[4:3]),
    .match    (chk_match)
  );

  always_comb begin
    case (q_type)
      2'b00:   perm = cur_cfg[0];
      2'b01:   perm = cur_cfg[1];
      2'b10:   perm = cur_cfg[2];
      default: perm = 1'b0;
    endcase
  end

  assign allow_now = (q_priv & ~cur_cfg[7]) | perm;
  assign accept    = req_valid & req_ready;
  assign reserved  = (req_size == 2'b10) || (req_type == 2'b11);
  assign req_ready = (state == IDLE);
  assign busy      = (state == SCAN);
  assign rsp_valid = (state == RESP);

`ifdef PMP_FIXED_LATENCY_EN
  assign scan_done = p_vld & p_last;
  assign res_hit   = found | p_match;
  assign res_entry = found ? f_idx : (p_match ? p_idx : 4'd0);
  assign res_allow = found ? f_allow : (p_match ? p_allow : q_priv);
`else
  assign scan_done = p_vld & (p_match | p_last);
  assign res_hit   = p_match;
  assign res_entry = p_match ? p_idx : 4'd0;
  assign res_allow = p_match ? p_allow : q_priv;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = reserved ? RESP : SCAN;
      SCAN:    if (scan_done) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 4'd0;
      q_addr    <= 32'h0;
      q_size    <= 2'b00;
      q_type    <= 2'b00;
      q_priv    <= 1'b0;
      p_vld     <= 1'b0;
      p_match   <= 1'b0;
      p_allow   <= 1'b0;
      p_last    <= 1'b0;
      p_idx     <= 4'd0;
      rsp_allow <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_entry <= 4'd0;
`ifdef PMP_FIXED_LATENCY_EN
      found     <= 1'b0;
      f_allow   <= 1'b0;
      f_idx     <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          q_addr    <= req_addr;
          q_size    <= req_size;
          q_type    <= req_type;
          q_priv    <= req_priv_m;
          idx       <= 4'd0;
          p_vld     <= 1'b0;
          rsp_allow <= 1'b0;
          rsp_hit   <= 1'b0;
          rsp_entry <= 4'd0;
`ifdef PMP_FIXED_LATENCY_EN
          found     <= 1'b0;
`endif
        end
        SCAN: begin
          p_vld   <= 1'b1;
          p_match <= chk_match;
          p_allow <= allow_now;
          p_idx   <= idx;
          p_last  <= (idx == LAST);
          if (idx != LAST) idx <= idx + 4'd1;
`ifdef PMP_FIXED_LATENCY_EN
          if (p_vld && p_match && !found) begin
            found   <= 1'b1;
            f_allow <= p_allow;
            f_idx   <= p_idx;
          end
`endif
          if (scan_done) begin
            rsp_hit   <= res_hit;
            rsp_allow <= res_allow;
            rsp_entry <= res_entry;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pmp_seq_checker.sv
// Randomized self-checking bench for pmp_seq_checker against a byte-range reference model.
module tb_pmp_seq_checker;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_priv_m;
  logic [31:0] req_addr;
  logic [1:0] req_size, req_type;
  logic [N-1:0][7:0] pmpcfg;
  logic [N-1:0][31:0] pmpaddr;
  logic rsp_valid, rsp_ready, rsp_allow, rsp_hit, busy;
  logic [3:0] rsp_entry;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pmp_seq_checker #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_type(req_type),
    .req_priv_m(req_priv_m), .pmpcfg(pmpcfg), .pmpaddr(pmpaddr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_allow(rsp_allow),
    .rsp_hit(rsp_hit), .rsp_entry(rsp_entry), .busy(busy)
  );

  // Reference: each entry describes a byte range [lo, hi); first entry containing all bytes wins.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                                input logic pm, output logic hit, output logic allow,
                                output logic [3:0] ent, output int lat);
    longint lo, hi, first, last;
    int k;
    logic [31:0] v;
    logic pr;
    hit = 1'b0; allow = pm; ent = 4'd0;
`ifdef PMP_FIXED_LATENCY_EN
    lat = N + 1;
`else
    lat = N + 1;
`endif
    if (sz == 2'b10 || ty == 2'b11) begin
      allow = 1'b0; lat = 0;
      return;
    end
    first = longint'({32'h0, a});
    last  = first + ((sz == 2'b00) ? 0 : (sz == 2'b01) ? 1 : 3);
    for (int i = 0; i < N; i++) begin
      v = pmpaddr[i];
      case (pmpcfg[i][4:3])
        2'b01: begin lo = (i == 0) ? 0 : longint'({32'h0, pmpaddr[i-1]}) * 4; hi = longint'({32'h0, v}) * 4; end
        2'b10: begin lo = longint'({32'h0, v}) * 4; hi = lo + 4; end
        2'b11: begin
          k = 0;
          while (k < 32 && v[k]) k++;
          lo = (longint'({32'h0, v}) >> (k + 1)) << (k + 3);
          hi = lo + (longint'(1) << (k + 3));
        end
        default: begin lo = 0; hi = 0; end
      endcase
      if (first >= lo && last < hi) begin
        case (ty)
          2'b00: pr = pmpcfg[i][0];
          2'b01: pr = pmpcfg[i][1];
          default: pr = pmpcfg[i][2];
        endcase
        hit = 1'b1; ent = 4'(i);
        allow = (pm & ~pmpcfg[i][7]) | pr;
`ifndef PMP_FIXED_LATENCY_EN
        lat = i + 2;
`endif
        return;
      end
    end
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin pmpcfg[i] = 8'h00; pmpaddr[i] = 32'h0; end
  endtask

  // Drives one request; lat = edges from acceptance to rsp_valid, -1 on timeout.
  task automatic send_req(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                          input logic pm, output int lat);
    req_addr = a; req_size = sz; req_type = ty; req_priv_m = pm; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string name, input logic [31:0] a, input logic [1:0] sz,
                           input logic [1:0] ty, input logic pm, input int lat);
    logic eh, ea; logic [3:0] ee; int el;
    model(a, sz, ty, pm, eh, ea, ee, el);
    checks++; if (lat !== el) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, el); end
    checks++; if (rsp_hit !== eh) begin errors++; $display("FAIL %s hit: got %b expected %b", name, rsp_hit, eh); end
    checks++; if (rsp_entry !== ee) begin errors++; $display("FAIL %s entry: got %0d expected %0d", name, rsp_entry, ee); end
    checks++; if (rsp_allow !== ea) begin errors++; $display("FAIL %s allow: got %b expected %b", name, rsp_allow, ea); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_allow, rsp_hit, rsp_entry} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 100000000", {req_ready, busy, rsp_valid, rsp_allow, rsp_hit, rsp_entry});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_tor_hit();
    int lat;
    clear_cfg();
    pmpaddr[0] = 32'h1234567E; pmpcfg[0] = 8'h0B;
    send_req(32'h1234566D, 2'b00, 2'b00, 1'b0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL tor_latency: got %0d expected 2", lat); end
    checks++; if ({rsp_hit, rsp_entry, rsp_allow} !== 6'b1_0000_1) begin
      errors++; $display("FAIL tor_fields: got %b expected 100001", {rsp_hit, rsp_entry, rsp_allow}); end
    consume();
  endtask

  task automatic test_na4_deny();
    int lat;
    clear_cfg();
    pmpaddr[5] = 32'h0000_1000; pmpcfg[5] = 8'h11;
    send_req(32'h0000_4002, 2'b00, 2'b01, 1'b0, lat);
    check_rsp("na4_deny", 32'h0000_4002, 2'b00, 2'b01, 1'b0, lat);
    checks++; if (rsp_entry !== 4'd5 || rsp_allow !== 1'b0) begin
      errors++; $display("FAIL na4_literal: got entry %0d allow %b expected entry 5 allow 0", rsp_entry, rsp_allow); end
    consume();
  endtask

  task automatic test_no_match();
    int lat;
    clear_cfg();
    for (int m = 0; m < 2; m++) begin
      send_req(32'h0000_8000, 2'b11, 2'b00, 1'(m), lat);
      checks++; if (lat !== 17 || rsp_hit !== 1'b0 || rsp_allow !== 1'(m)) begin
        errors++; $display("FAIL no_match_m%0d: got lat %0d hit %b allow %b expected lat 17 hit 0 allow %0d", m, lat, rsp_hit, rsp_allow, m); end
      consume();
    end
  endtask

  task automatic test_lock();
    int lat;
    clear_cfg();
    pmpaddr[0] = 32'h0000_1000; pmpcfg[0] = 8'h90;
    send_req(32'h0000_4000, 2'b00, 2'b00, 1'b1, lat);
    checks++; if (rsp_allow !== 1'b0 || rsp_hit !== 1'b1) begin
      errors++; $display("FAIL lock_set: got allow %b hit %b expected allow 0 hit 1", rsp_allow, rsp_hit); end
    consume();
    pmpcfg[0] = 8'h10;
    send_req(32'h0000_4000, 2'b00, 2'b00, 1'b1, lat);
    checks++; if (rsp_allow !== 1'b1 || rsp_hit !== 1'b1) begin
      errors++; $display("FAIL lock_clear: got allow %b hit %b expected allow 1 hit 1", rsp_allow, rsp_hit); end
    consume();
  endtask

  task automatic test_reserved();
    int lat;
    clear_cfg();
    pmpaddr[0] = 32'hFFFF_FFFF; pmpcfg[0] = 8'h1F;
    send_req(32'h0000_0100, 2'b10, 2'b00, 1'b1, lat);
    check_rsp("reserved_size", 32'h0000_0100, 2'b10, 2'b00, 1'b1, lat);
    consume();
    send_req(32'h0000_0100, 2'b00, 2'b11, 1'b1, lat);
    check_rsp("reserved_type", 32'h0000_0100, 2'b00, 2'b11, 1'b1, lat);
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [5:0] snap;
    clear_cfg();
    pmpaddr[2] = 32'h0000_003F; pmpcfg[2] = 8'h1C;
    send_req(32'h0000_0010, 2'b11, 2'b10, 1'b0, lat);
    check_rsp("bp_resp", 32'h0000_0010, 2'b11, 2'b10, 1'b0, lat);
    snap = {rsp_hit, rsp_entry, rsp_allow};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if ({rsp_valid, req_ready, rsp_hit, rsp_entry, rsp_allow} !== {2'b10, snap}) begin
        errors++; $display("FAIL bp_hold%0d: got %b expected %b", c, {rsp_valid, req_ready, rsp_hit, rsp_entry, rsp_allow}, {2'b10, snap}); end
    end
    consume();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid %b ready %b expected 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    clear_cfg();
    req_addr = 32'h0000_0040; req_size = 2'b00; req_type = 2'b00; req_priv_m = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_allow, rsp_hit, rsp_entry} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_mid_scan: got %b expected 100000000", {req_ready, busy, rsp_valid, rsp_allow, rsp_hit, rsp_entry});
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_discard: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a;
    logic [1:0] sz, ty;
    logic pm;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        pmpcfg[i]  = {($urandom_range(0, 3) == 0), 2'b00, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
        pmpaddr[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 80));
      end
      a  = 32'($urandom_range(0, 360));
      sz = 2'($urandom_range(0, 3));
      ty = 2'($urandom_range(0, 3));
      pm = 1'($urandom_range(0, 1));
      send_req(a, sz, ty, pm, lat);
      check_rsp("random", a, sz, ty, pm, lat);
      consume();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = 32'h0; req_size = 2'b00; req_type = 2'b00; req_priv_m = 1'b0;
    clear_cfg();
    test_reset();
    test_tor_hit();
    test_na4_deny();
    test_no_match();
    test_lock();
    test_reserved();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
